// File: rtl/osc_gate_sequencer.sv
// Sequenced oscillator frequency measurement: enable, settle, count edges over a gate window.
// Optional OSC_GATE_CONT_EN adds a cont input for back-to-back windows without re-settling.
module osc_gate_sequencer #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned GATE_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc_in,
`ifdef OSC_GATE_CONT_EN
    input  logic              cont,
`endif
    output logic              osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

    state_e              state_q, state_d;
    logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                osc_edge;
    logic                gate_last;

    assign osc_edge  = s2_q & ~s3_q;
    assign gate_last = (gate_q == '0) || (gate_cnt_q == gate_q - GATE_W'(1));

    always_comb begin
        state_d    = state_q;
        s1_d       = osc_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        gate_d     = gate_q;
        gate_cnt_d = gate_cnt_q;
        settle_d   = settle_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        osc_en     = 1'b0;
        done       = 1'b0;
        busy       = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d   = gate_len;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                osc_en = 1'b1;
                if (settle_q == SettleLast) begin
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    gate_cnt_d = '0;
                    state_d    = StGate;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StGate: begin
                osc_en     = 1'b1;
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                // A zero-length gate still spends one cycle here but must report zero.
                if (osc_edge && (gate_q != '0)) begin
                    if (edge_cnt_q == '1) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (gate_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done       = 1'b1;
                count_d    = edge_cnt_q;
                overflow_d = sat_q;
                state_d    = StIdle;
`ifdef OSC_GATE_CONT_EN
                if (cont) begin
                    osc_en     = 1'b1;
                    gate_d     = gate_len;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                    state_d    = StGate;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            gate_q     <= '0;
            gate_cnt_q <= '0;
            settle_q   <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            gate_q     <= gate_d;
            gate_cnt_q <= gate_cnt_d;
            settle_q   <= settle_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_osc_gate_sequencer.sv
// Directed, table-driven bench for osc_gate_sequencer (default and 4-bit counter instances).
module tb_osc_gate_sequencer;

    localparam int SETTLE = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;
    logic        osc_in = 1'b0;
    logic        osc_en, busy, done, overflow;
    logic [15:0] count;
    logic        s_osc_en, s_busy, s_done, s_overflow;
    logic [3:0]  s_count;
`ifdef OSC_GATE_CONT_EN
    logic        cont = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hp = 0;
    logic lvl = 1'b0;
    int ph = 0;

    always #5 clk = ~clk;

    // Oscillator model: toggles every hp clk cycles, or holds lvl when hp==0.
    always @(posedge clk) begin
        #3;
        if (hp == 0) begin
            osc_in = lvl;
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph >= hp) begin
                ph = 0;
                osc_in = ~osc_in;
            end
        end
    end

    osc_gate_sequencer #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_in(osc_in),
`ifdef OSC_GATE_CONT_EN
        .cont(cont),
`endif
        .osc_en(osc_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    osc_gate_sequencer #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(SETTLE)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .osc_in(osc_in),
`ifdef OSC_GATE_CONT_EN
        .cont(cont),
`endif
        .osc_en(s_osc_en), .busy(s_busy), .done(s_done), .count(s_count),
        .overflow(s_overflow)
    );

    task automatic chk(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One measurement; optionally re-pulses start with another gate_len at cycle restart_at.
    task automatic run(input int g, input int pre, input int restart_at, output int lat,
                       output int nbusy, output int nosc, output int ndone, output int sdone);
        int cyc;
        lat = -1; nbusy = 0; nosc = 0; ndone = 0; sdone = 0;
        repeat (pre) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        gate_len = 16'(g);
        @(negedge clk);
        start = 1'b0;
        gate_len = 16'hffff;
        cyc = 1;
        while (cyc < 3000) begin
            if (busy) nbusy++;
            if (osc_en) nosc++;
            if (s_done) sdone++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = cyc;
            end
            if (cyc == restart_at) begin
                start = 1'b1;
                gate_len = 16'd500;
            end else begin
                start = 1'b0;
            end
            if (!busy) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int   g;
        int   hp;
        logic lvl;
        int   pre;
        int   lo;
        int   hi;
        logic ovf;
        int   slo;
        int   shi;
        logic sovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, nb, no, nd, sd, gm;

        vecs[0] = '{1000, 5, 1'b0, 0, 99, 101, 1'b0, 15, 15, 1'b1};
        vecs[1] = '{0,    1, 1'b0, 0, 0,  0,   1'b0, 0,  0,  1'b0};
        vecs[2] = '{0,    1, 1'b0, 1, 0,  0,   1'b0, 0,  0,  1'b0};
        vecs[3] = '{1,    0, 1'b0, 0, 0,  0,   1'b0, 0,  0,  1'b0};
        vecs[4] = '{50,   2, 1'b0, 0, 12, 13,  1'b0, 12, 13, 1'b0};
        vecs[5] = '{20,   1, 1'b0, 0, 10, 10,  1'b0, 10, 10, 1'b0};
        vecs[6] = '{7,    0, 1'b1, 0, 0,  0,   1'b0, 0,  0,  1'b0};
        vecs[7] = '{200,  2, 1'b0, 0, 49, 51,  1'b0, 15, 15, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_osc_en", int'(osc_en), 0, 0);
        chk("rst_done", int'(done), 0, 0);
        chk("rst_count", int'(count), 0, 0);
        chk("rst_overflow", int'(overflow), 0, 0);

        for (int i = 0; i < 8; i++) begin
            hp = vecs[i].hp;
            lvl = vecs[i].lvl;
            gm = (vecs[i].g == 0) ? 1 : vecs[i].g;
            run(vecs[i].g, vecs[i].pre, 0, lat, nb, no, nd, sd);
            $display("vector %0d: gate_len=%0d count=%0d sat_count=%0d", i, vecs[i].g, count,
                     s_count);
            chk($sformatf("v%0d_latency", i), lat, SETTLE + gm + 1, SETTLE + gm + 1);
            chk($sformatf("v%0d_busy_cycles", i), nb, SETTLE + gm + 1, SETTLE + gm + 1);
            chk($sformatf("v%0d_osc_en_cycles", i), no, SETTLE + gm, SETTLE + gm);
            chk($sformatf("v%0d_done_pulses", i), nd, 1, 1);
            chk($sformatf("v%0d_count", i), int'(count), vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].ovf),
                int'(vecs[i].ovf));
            chk($sformatf("v%0d_sat_count", i), int'(s_count), vecs[i].slo, vecs[i].shi);
            chk($sformatf("v%0d_sat_overflow", i), int'(s_overflow), int'(vecs[i].sovf),
                int'(vecs[i].sovf));
        end

        // Start re-pulsed mid-GATE with gate_len=500 must be ignored.
        hp = 1;
        run(30, 0, SETTLE + 10, lat, nb, no, nd, sd);
        chk("restart_latency", lat, SETTLE + 31, SETTLE + 31);
        chk("restart_done_pulses", nd, 1, 1);
        chk("restart_count", int'(count), 15, 15);
        run(10, 2, 0, lat, nb, no, nd, sd);
        chk("next_latency", lat, SETTLE + 11, SETTLE + 11);
        chk("next_count", int'(count), 5, 5);

        // Reset asserted mid-GATE after a nonzero result is held.
        hp = 5;
        @(negedge clk);
        start = 1'b1;
        gate_len = 16'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        chk("pre_reset_osc_en", int'(osc_en), 1, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0, 0);
        chk("mid_rst_osc_en", int'(osc_en), 0, 0);
        chk("mid_rst_done", int'(done), 0, 0);
        chk("mid_rst_count", int'(count), 0, 0);
        chk("mid_rst_overflow", int'(overflow), 0, 0);
        chk("mid_rst_sat_overflow", int'(s_overflow), 0, 0);
        @(negedge clk);
        chk("post_rst_idle", int'(busy), 0, 0);

`ifdef OSC_GATE_CONT_EN
        begin
            int cyc, last, ndn, nlow;
            cyc = 0; last = -1; ndn = 0; nlow = 0;
            hp = 5;
            cont = 1'b1;
            @(negedge clk);
            start = 1'b1;
            gate_len = 16'd100;
            @(negedge clk);
            start = 1'b0;
            while (ndn < 3 && cyc < 3000) begin
                cyc++;
                if (ndn > 0 && !osc_en) nlow++;
                if (done) begin
                    if (ndn == 0) chk("cont_first_latency", cyc, SETTLE + 101, SETTLE + 101);
                    else chk("cont_interval", cyc - last, 101, 101);
                    chk("cont_count", int'(count), 9, 11);
                    last = cyc;
                    ndn++;
                    if (ndn == 3) cont = 1'b0;
                end
                if (ndn < 3) @(negedge clk);
            end
            chk("cont_done_pulses", ndn, 3, 3);
            chk("cont_osc_en_low_cycles", nlow, 0, 0);
            @(negedge clk);
            chk("cont_exit_busy", int'(busy), 0, 0);
            chk("cont_exit_osc_en", int'(osc_en), 0, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
